audio_i2s_tx: RTL and testbench

//  Audio output stage fed by the baseband demodulator's l_out/r_out/valid strobe.

---
 rtl/audio_i2s_tx.sv | 128 ++++++++++++
 tb/tb_audio_i2s_tx.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/audio_i2s_tx.sv
// audio_i2s_tx: FIFO-buffered stereo I2S master transmitter.
// Ports: clk, reset_n, l_in/r_in/ena (sample in), clr (flag clear),
//        bclk/lrck/sdata (I2S out), level (FIFO occupancy), ovf/udf (sticky flags).
module audio_i2s_tx #(
  parameter int dsz  = 16,
  parameter int slot = 32,
  parameter int div  = 4,
  parameter int aw   = 2
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic [dsz-1:0] l_in,
  input  logic [dsz-1:0] r_in,
  input  logic           ena,
  input  logic           clr,
  output logic           bclk,
  output logic           lrck,
  output logic           sdata,
  output logic [aw:0]    level,
  output logic           ovf,
  output logic           udf
);

  localparam int depth = 2**aw;
  localparam int fl    = 2*slot;
  localparam int pw    = $clog2(fl);
  localparam int cw    = (div > 1) ? $clog2(div) : 1;

  logic [cw-1:0]    cnt;
  logic [pw-1:0]    p;
  logic [pw-1:0]    p_nxt;
  logic [pw-1:0]    q;
  logic             tick;
  logic             fe;
  logic             wrap;
  logic             right;
  logic             lrck_nxt;
  logic             bit_nxt;

  logic [2*dsz-1:0] mem [depth];
  logic [aw-1:0]    wp;
  logic [aw-1:0]    rp;
  logic             empty;
  logic             full;
  logic             pop;
  logic             push;

  // cur is both the pair being serialized and the repeat source on underrun
  logic [2*dsz-1:0] cur;
  logic [2*dsz-1:0] src;
  logic [2*dsz-1:0] pair;
  logic [dsz-1:0]   word;
  logic [dsz-1:0]   shw;

  assign tick  = (cnt == cw'(div-1));
  assign fe    = tick & bclk;
  assign p_nxt = (p == pw'(fl-1)) ? '0 : p + pw'(1);
  assign wrap  = fe & (p_nxt == '0);

  assign empty = (level == '0);
  assign full  = (level == (aw+1)'(depth));
  assign pop   = wrap & ~empty;
  assign push  = ena & (~full | pop);

  assign src  = empty ? cur : mem[rp];
  // on the load edge the new pair must drive the left MSB directly
  assign pair = wrap ? src : cur;

  assign right = (p_nxt >= pw'(slot));
  assign q     = right ? p_nxt - pw'(slot) : p_nxt;
  assign word  = right ? pair[dsz-1:0] : pair[2*dsz-1:dsz];
  // shifting past dsz leaves zeros, which pads the tail of the slot
  assign shw     = word << q;
  assign bit_nxt = shw[dsz-1];

  assign lrck_nxt = (p_nxt >= pw'(slot-1)) &&
                    (p_nxt <= pw'(fl-2));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt   <= '0;
      bclk  <= 1'b0;
      p     <= pw'(fl-1);
      lrck  <= 1'b0;
      sdata <= 1'b0;
      cur   <= '0;
    end else begin
      if (tick) begin
        cnt  <= '0;
        bclk <= ~bclk;
      end else begin
        cnt  <= cnt + cw'(1);
      end
      if (fe) begin
        p     <= p_nxt;
        lrck  <= lrck_nxt;
        sdata <= bit_nxt;
      end
      if (wrap) cur <= src;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wp    <= '0;
      rp    <= '0;
      level <= '0;
      ovf   <= 1'b0;
      udf   <= 1'b0;
    end else begin
      if (push) wp <= wp + aw'(1);
      if (pop)  rp <= rp + aw'(1);
      unique case ({push, pop})
        2'b10:   level <= level + (aw+1)'(1);
        2'b01:   level <= level - (aw+1)'(1);
        default: level <= level;
      endcase
      ovf <= (ena & ~push) | (ovf & ~clr);
      udf <= (wrap & empty) | (udf & ~clr);
    end
  end

  // storage has no reset; the pointers define what is valid
  always_ff @(posedge clk) begin
    if (push) mem[wp] <= {l_in, r_in};
  end

endmodule

// File: tb/tb_audio_i2s_tx.sv
// tb_audio_i2s_tx: directed bench for audio_i2s_tx.
// Samples the I2S stream on bclk rising edges and compares whole frames.
module tb_audio_i2s_tx;

  localparam logic [63:0] LR_EXP = 64'h0000_0001_FFFF_FFFE;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        ena = 1'b0;
  logic        clr = 1'b0;
  logic [15:0] l_in = '0;
  logic [15:0] r_in = '0;
  logic        bclk;
  logic        lrck;
  logic        sdata;
  logic [2:0]  level;
  logic        ovf;
  logic        udf;

  int n_chk  = 0;
  int n_fail = 0;
  int gap;
  bit edge_bad;
  bit gap_bad;
  bit tmo;

  audio_i2s_tx #(
    .dsz  (16),
    .slot (32),
    .div  (2),
    .aw   (2)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .l_in    (l_in),
    .r_in    (r_in),
    .ena     (ena),
    .clr     (clr),
    .bclk    (bclk),
    .lrck    (lrck),
    .sdata   (sdata),
    .level   (level),
    .ovf     (ovf),
    .udf     (udf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] fr(input logic [15:0] l,
                                     input logic [15:0] r);
    return {l, 16'h0, r, 16'h0};
  endfunction

  // wait for the next bclk rising edge, return lrck/sdata there
  task automatic next_bit(output logic lr, output logic sd);
    logic pb;
    logic ps;
    bit   got;
    int   n;
    pb  = bclk;
    ps  = sdata;
    got = 0;
    n   = 0;
    while (!got && n < 16) begin
      @(posedge clk);
      #1;
      n++;
      if (sdata !== ps && !(pb && !bclk)) edge_bad = 1;
      ps = sdata;
      if (!pb && bclk) got = 1;
      pb = bclk;
    end
    if (!got) tmo = 1;
    gap = n;
    lr  = lrck;
    sd  = sdata;
  endtask

  task automatic frame(input string tag,
                       input logic [15:0] l,
                       input logic [15:0] r);
    logic [63:0] sv;
    logic [63:0] lv;
    logic a;
    logic b;
    edge_bad = 0;
    gap_bad  = 0;
    tmo      = 0;
    for (int i = 0; i < 64; i++) begin
      next_bit(a, b);
      sv[63-i] = b;
      lv[63-i] = a;
      if (i > 0 && gap != 4) gap_bad = 1;
    end
    chk({tag, "_sdata"}, sv, fr(l, r));
    chk({tag, "_lrck"}, lv, LR_EXP);
    chk({tag, "_bclk"}, 64'(gap_bad | tmo), 64'd0);
    chk({tag, "_edge"}, 64'(edge_bad), 64'd0);
  endtask

  // align to the last bit of a frame (lrck sampled 1 then 0)
  task automatic sync();
    logic a;
    logic b;
    bit   seen;
    bit   done;
    seen = 0;
    done = 0;
    for (int i = 0; i < 200 && !done; i++) begin
      next_bit(a, b);
      if (a) seen = 1;
      else if (seen) done = 1;
    end
    chk("sync", 64'(done), 64'd1);
  endtask

  task automatic release_rst(input logic [15:0] l,
                             input logic [15:0] r);
    @(negedge clk);
    reset_n = 1'b1;
    ena     = 1'b1;
    l_in    = l;
    r_in    = r;
    @(negedge clk);
    ena = 1'b0;
    chk("rel_level", 64'(level), 64'd1);
    chk("rel_ovf", 64'(ovf), 64'd0);
  endtask

  task automatic wr(input logic [15:0] l, input logic [15:0] r);
    ena  = 1'b1;
    l_in = l;
    r_in = r;
    @(posedge clk);
    #1;
    ena = 1'b0;
  endtask

  task automatic rst_vals(input string tag);
    chk({tag, "_bclk"},  64'(bclk),  64'd0);
    chk({tag, "_lrck"},  64'(lrck),  64'd0);
    chk({tag, "_sdata"}, 64'(sdata), 64'd0);
    chk({tag, "_level"}, 64'(level), 64'd0);
    chk({tag, "_ovf"},   64'(ovf),   64'd0);
    chk({tag, "_udf"},   64'(udf),   64'd0);
  endtask

  initial begin
    logic a;
    logic b;

    repeat (5) @(negedge clk);
    rst_vals("rst");

    release_rst(16'h8001, 16'h7FFE);
    next_bit(a, b);
    chk("pre_lrck", 64'(a), 64'd0);
    chk("pre_sdata", 64'(b), 64'd0);
    frame("f1", 16'h8001, 16'h7FFE);
    chk("f1_udf", 64'(udf), 64'd0);
    chk("f1_level", 64'(level), 64'd0);

    frame("f2rep", 16'h8001, 16'h7FFE);
    chk("f2_udf", 64'(udf), 64'd1);
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    chk("clr_udf", 64'(udf), 64'd0);
    frame("f3rep", 16'h8001, 16'h7FFE);
    chk("f3_udf", 64'(udf), 64'd1);

    repeat (2) @(posedge clk);
    #1;
    for (int k = 1; k <= 5; k++) wr(16'(k), 16'(-k));
    chk("burst_level", 64'(level), 64'd4);
    chk("burst_ovf", 64'(ovf), 64'd1);
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    chk("clr2_ovf", 64'(ovf), 64'd0);
    chk("clr2_udf", 64'(udf), 64'd0);

    sync();
    frame("p1", 16'h0001, 16'hFFFF);
    frame("p2", 16'h0002, 16'hFFFE);
    frame("p3", 16'h0003, 16'hFFFD);
    frame("p4", 16'h0004, 16'hFFFC);
    chk("p4_udf", 64'(udf), 64'd0);
    chk("p4_level", 64'(level), 64'd0);
    frame("p4rep", 16'h0004, 16'hFFFC);
    chk("p4rep_udf", 64'(udf), 64'd1);

    repeat (2) @(posedge clk);
    #1;
    wr(16'h1111, 16'h2222);
    wr(16'h3333, 16'h4444);
    wr(16'h5555, 16'h6666);
    wr(16'h7777, 16'h0888);
    chk("fill_level", 64'(level), 64'd4);
    repeat (251) @(posedge clk);
    #1;
    chk("pre_pop_level", 64'(level), 64'd4);
    wr(16'h0999, 16'h0AAA);
    chk("pop_wr_level", 64'(level), 64'd4);
    chk("pop_wr_ovf", 64'(ovf), 64'd0);
    frame("fa", 16'h1111, 16'h2222);

    for (int i = 0; i < 40; i++) next_bit(a, b);
    chk("mid_lrck", 64'(lrck), 64'd1);
    chk("mid_level", 64'(level), 64'd3);
    #3;
    reset_n = 1'b0;
    #1;
    rst_vals("arst");

    repeat (3) @(negedge clk);
    release_rst(16'h1234, 16'hABCD);
    next_bit(a, b);
    frame("fg", 16'h1234, 16'hABCD);
    chk("fg_udf", 64'(udf), 64'd0);
    chk("fg_level", 64'(level), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
